outerprodrc_drain: RTL and testbench
====================================

// Module: outerprodrc_drain
// PURPOSE
// - Sequencer and reader for the rate-coded outer-product array (outerprodrc).
// - Runs one unary accumulation window on the array (drives its iEn/iClr),
//   snapshots the ROWNUM*COLNUM accumulators, then streams them out one per beat.
// - Sits between outerprodrc and the downstream consumer; the array stays unmodified.
// PARAMETERS
// - ROWNUM      2   rows in the array
// - COLNUM      2   columns in the array
// - BITWIDTH    4   input width, sign-magnitude; RUNLEN = 2**(BITWIDTH-1) = 8 cycles
// - OUTBITWIDTH 8   accumulator/element width, passed through opaquely
// PORTS
// - iClk     in   1                          clock, rising edge
// - iRstN    in   1                          async reset, active low
// - iStart   in   1                          request one run+drain; sampled in IDLE only
// - oEn      out  1                          to array iEn
// - oClr     out  1                          to array iClr
// - iAccData in   ROWNUM*COLNUM*OUTBITWIDTH  array oData
// - oData    out  OUTBITWIDTH                streamed element
// - oIdx     out  clog2(ROWNUM*COLNUM)       element index, r*COLNUM+c
// - oValid   out  1                          oData/oIdx valid
// - iReady   in   1                          consumer accepts
// - oLast    out  1                          current beat is idx ROWNUM*COLNUM-1
// - oBusy    out  1                          state != IDLE
// - oDone    out  1                          1-cycle pulse after final handshake
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, snapshot 0. Async assert, takes
//   effect immediately mid-operation; no partial drain resumes after release.
// - FSM IDLE -> CLR -> RUN -> SETTLE -> CAPTURE -> DRAIN -> IDLE.
//   IDLE:    oEn=0, oClr=0; iStart=1 -> CLR.
//   CLR:     1 cycle, oClr=1, oEn=0.
//   RUN:     oEn=1 for exactly RUNLEN cycles (run counter 0..RUNLEN-1), oClr=0.
//   SETTLE:  1 cycle, oEn=0; absorbs the array's registered last update.
//   CAPTURE: 1 cycle; snapshot <= iAccData.
//   DRAIN:   oValid=1; element idx = snapshot[idx*OUTBITWIDTH +: OUTBITWIDTH];
//            idx advances only on oValid&iReady; oData/oIdx held stable while stalled.
//            Handshake on last idx -> IDLE, oDone=1 for the next cycle only.
// - First oValid rises RUNLEN+3 cycles after the iStart sample; with iReady tied 1,
//   ROWNUM*COLNUM back-to-back beats follow.
// - oValid never deasserts before its handshake; iReady is free to toggle.
// - iStart outside IDLE is ignored (except as noted under CONFIGURATION); no queueing.
// - Index wrap: idx resets to 0 on leaving DRAIN; no idx beyond ROWNUM*COLNUM-1 is presented.
// - All outputs are registered; no combinational path from iReady to oValid.
// CONFIGURATION
// - OUTERPRODRC_DRAIN_OVERLAP_EN defined:
//   - iStart is also accepted in DRAIN. The next CLR/RUN proceeds in parallel with the
//     drain, from the decoupled snapshot.
//   - If that run reaches CAPTURE before the drain finishes, the FSM holds in SETTLE
//     (oEn=0) until the last handshake, then captures.
//   - oDone pulses per completed drain; oBusy stays 1 across back-to-back runs.
// - Undefined: strictly serial; iStart in DRAIN is ignored.
// TESTING (2x2, BITWIDTH 4, OUTBITWIDTH 8; stub drives
//   iAccData = {8'h04, 8'hFD, 8'h02, 8'h00}, idx3..idx0)
// - iStart pulse at cycle 0 -> oClr=1 cycle 1; oEn=1 cycles 2..9;
//   first oValid at cycle 11 with oIdx=0, oData=8'h00.
// - iReady=1 throughout -> beats idx0..3 = 00, 02, FD, 04 on consecutive cycles;
//   oLast only on idx3; oDone=1 the cycle after; oBusy=0 after.
// - iReady=0 for 3 cycles at idx1 -> oData held 8'h02, oIdx held 1, oValid held 1;
//   resumes on iReady=1.
// - iStart re-pulsed during RUN (macro off) -> oEn total still exactly 8 cycles;
//   one drain only.
// - iRstN=0 mid-DRAIN at idx2 -> oValid, oEn, oClr, oBusy = 0 immediately;
//   after release, IDLE with no output until a new iStart.
// - Macro on, iStart during DRAIN -> oClr while draining, 8 oEn cycles;
//   second drain starts only after the first oDone, with the fresh snapshot.

Source files
------------

// File: rtl/outerprodrc_drain.sv
// Sequencer and reader for the rate-coded outer-product array.
// One start request runs a single window on the array: a clear cycle, then RUNLEN enable
// cycles. It then snapshots every accumulator and streams them out one per valid/ready beat.
// Optional feature macro: OUTERPRODRC_DRAIN_OVERLAP_EN.
//   Defined:   a start request is also accepted while draining. The next run proceeds in
//              parallel from the decoupled snapshot.
//   Undefined: strictly serial operation.
module outerprodrc_drain #(
  parameter int unsigned ROWNUM      = 2,
  parameter int unsigned COLNUM      = 2,
  parameter int unsigned BITWIDTH    = 4,
  parameter int unsigned OUTBITWIDTH = 8,
  localparam int unsigned NUMEL      = ROWNUM * COLNUM,
  localparam int unsigned IDXW       = (NUMEL > 1) ? $clog2(NUMEL) : 1
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iStart,
  output logic                         oEn,
  output logic                         oClr,
  input  logic [NUMEL*OUTBITWIDTH-1:0] iAccData,
  output logic [OUTBITWIDTH-1:0]       oData,
  output logic [IDXW-1:0]              oIdx,
  output logic                         oValid,
  input  logic                         iReady,
  output logic                         oLast,
  output logic                         oBusy,
  output logic                         oDone
);

  localparam int unsigned RUNLEN = 2 ** (BITWIDTH - 1);
  localparam int unsigned CNTW   = (RUNLEN > 1) ? $clog2(RUNLEN) : 1;
  localparam logic [CNTW-1:0] RunLast = CNTW'(RUNLEN - 1);
  localparam logic [IDXW-1:0] IdxLast = IDXW'(NUMEL - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StRun,
    StSettle,
    StCapture,
    StDrain
  } stateT;

  stateT                         stateQ, stateD;
  logic [CNTW-1:0]               runCntQ, runCntD;
  logic [IDXW-1:0]               idxQ, idxD;
  logic [NUMEL*OUTBITWIDTH-1:0]  snapQ, snapD;
  logic                          enQ, enD;
  logic                          clrQ, clrD;
  logic                          validQ, validD;
  logic                          lastQ, lastD;
  logic                          busyQ, busyD;
  logic                          doneQ, doneD;
  logic [OUTBITWIDTH-1:0]        dataQ, dataD;
  logic                          hs;
  logic                          lastHs;

  // Next state, counters, snapshot and the next value of every registered output.
  always_comb begin
    stateD  = stateQ;
    runCntD = runCntQ;
    idxD    = idxQ;
    snapD   = snapQ;
    hs      = validQ & iReady;
    lastHs  = hs && (idxQ == IdxLast);

    unique case (stateQ)
      StIdle: begin
        if (iStart) stateD = StClr;
      end
      StClr: begin
        stateD = StRun;
      end
      StRun: begin
        if (runCntQ == RunLast) begin
          stateD  = StSettle;
          runCntD = '0;
        end else begin
          runCntD = runCntQ + CNTW'(1);
        end
      end
      StSettle: begin
        // Wait here while a previous drain still needs the old snapshot.
        if (!validQ || lastHs) stateD = StCapture;
      end
      StCapture: begin
        stateD = lastHs ? StIdle : StDrain;
      end
      StDrain: begin
        if (lastHs) stateD = StIdle;
`ifdef OUTERPRODRC_DRAIN_OVERLAP_EN
        if (iStart) stateD = StClr;
`endif
      end
      default: begin
        stateD = StIdle;
      end
    endcase

    // The snapshot is taken on the edge into CAPTURE so that the first beat is already
    // presented during CAPTURE.
    if (stateD == StCapture) begin
      snapD = iAccData;
      idxD  = '0;
    end else if (lastHs) begin
      idxD = '0;
    end else if (hs) begin
      idxD = idxQ + IDXW'(1);
    end

    validD = (stateD == StCapture) || (validQ && !lastHs);
    lastD  = validD && (idxD == IdxLast);
    enD    = (stateD == StRun);
    clrD   = (stateD == StClr);
    busyD  = (stateD != StIdle);
    doneD  = lastHs;

    dataD = '0;
    if (validD) begin
      for (int unsigned i = 0; i < NUMEL; i++) begin
        if (idxD == IDXW'(i)) dataD = snapD[i*OUTBITWIDTH +: OUTBITWIDTH];
      end
    end
  end

  // State, counters, snapshot and output registers; reset clears any drain in progress.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      stateQ  <= StIdle;
      runCntQ <= '0;
      idxQ    <= '0;
      snapQ   <= '0;
      enQ     <= 1'b0;
      clrQ    <= 1'b0;
      validQ  <= 1'b0;
      lastQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      dataQ   <= '0;
    end else begin
      stateQ  <= stateD;
      runCntQ <= runCntD;
      idxQ    <= idxD;
      snapQ   <= snapD;
      enQ     <= enD;
      clrQ    <= clrD;
      validQ  <= validD;
      lastQ   <= lastD;
      busyQ   <= busyD;
      doneQ   <= doneD;
      dataQ   <= dataD;
    end
  end

  assign oEn    = enQ;
  assign oClr   = clrQ;
  assign oValid = validQ;
  assign oLast  = lastQ;
  assign oBusy  = busyQ;
  assign oDone  = doneQ;
  assign oData  = dataQ;
  assign oIdx   = idxQ;

endmodule

// File: tb/tb_outerprodrc_drain.sv
// Bench for outerprodrc_drain (2x2 array, BITWIDTH 4, OUTBITWIDTH 8).
// A stub drives the accumulator bus. Expected beats are queued when a run is started and
// are compared as the stream is accepted.
module tb_outerprodrc_drain;

  logic        iClk;
  logic        iRstN;
  logic        iStart;
  logic        oEn;
  logic        oClr;
  logic [31:0] iAccData;
  logic [7:0]  oData;
  logic [1:0]  oIdx;
  logic        oValid;
  logic        iReady;
  logic        oLast;
  logic        oBusy;
  logic        oDone;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       last;
  } beatT;

  beatT sbQ[$];
  int   checkCnt = 0;
  int   failCnt  = 0;
  int   enCount  = 0;
  int   enBefore;
  logic prevLastHs = 1'b0;

  outerprodrc_drain #(
    .ROWNUM     (2),
    .COLNUM     (2),
    .BITWIDTH   (4),
    .OUTBITWIDTH(8)
  ) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iStart  (iStart),
    .oEn     (oEn),
    .oClr    (oClr),
    .iAccData(iAccData),
    .oData   (oData),
    .oIdx    (oIdx),
    .oValid  (oValid),
    .iReady  (iReady),
    .oLast   (oLast),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue the four beats one drain should produce, element 0 first.
  task automatic pushRun(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] d [4];
    d = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) sbQ.push_back({2'(i), d[i], (i == 3)});
  endtask

  task automatic waitValid(input int maxCycles);
    bit seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge iClk);
      if (oValid) seen = 1'b1;
    end
    if (!seen) checkVal("validTimeout", {31'd0, oValid}, 32'd1);
  endtask

  task automatic waitDone(input int maxCycles);
    bit seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      @(negedge iClk);
      if (oDone) seen = 1'b1;
    end
    if (!seen) checkVal("doneTimeout", {31'd0, oDone}, 32'd1);
  endtask

  // One-cycle start pulse, driven just after a rising edge.
  task automatic pulseStart();
    @(posedge iClk);
    #1 iStart = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b0;
  endtask

  // Compare every accepted beat against the queue; oDone must follow the last beat.
  always @(negedge iClk) begin : monitor
    beatT e;
    if (iRstN) begin
      if (oDone || prevLastHs) checkVal("done", {31'd0, oDone}, {31'd0, prevLastHs});
      prevLastHs = 1'b0;
      if (oValid && iReady) begin
        if (sbQ.size() == 0) begin
          checkVal("beatUnexpected", {30'd0, oIdx}, 32'hFFFF_FFFF);
        end else begin
          e = sbQ.pop_front();
          checkVal("beatIdx", {30'd0, oIdx}, {30'd0, e.idx});
          checkVal("beatData", {24'd0, oData}, {24'd0, e.data});
          checkVal("beatLast", {31'd0, oLast}, {31'd0, e.last});
          prevLastHs = e.last;
        end
      end
      if (oEn) enCount++;
    end else begin
      prevLastHs = 1'b0;
    end
  end

  initial begin
    logic [2:0] expSeq;
    iRstN    = 1'b0;
    iStart   = 1'b0;
    iReady   = 1'b0;
    iAccData = {8'h04, 8'hFD, 8'h02, 8'h00};

    #12;
    checkVal("rstOut", {16'd0, oEn, oClr, oValid, oLast, oBusy, oDone, oData, oIdx}, 32'd0);
    @(negedge iClk);
    #1 iRstN = 1'b1;

    // Start-to-stream timing with iReady held high.
    iReady = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b1;
    pushRun(8'h00, 8'h02, 8'hFD, 8'h04);
    for (int c = 0; c <= 11; c++) begin
      @(negedge iClk);
      expSeq = {(c == 1), (c >= 2 && c <= 9), (c == 11)};
      checkVal($sformatf("seqCycle%0d", c), {29'd0, oClr, oEn, oValid}, {29'd0, expSeq});
      if (c == 0) begin
        @(posedge iClk);
        #1 iStart = 1'b0;
      end
    end
    waitDone(20);
    @(negedge iClk);
    checkVal("busyAfterDrain", {31'd0, oBusy}, 32'd0);

    // Three-cycle stall on element 1.
    iReady = 1'b0;
    pulseStart();
    pushRun(8'h00, 8'h02, 8'hFD, 8'h04);
    waitValid(20);
    @(posedge iClk);
    #1 iReady = 1'b1;
    @(posedge iClk);
    #1 iReady = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      checkVal("stallHold", {21'd0, oValid, oIdx, oData}, {21'd0, 1'b1, 2'd1, 8'h02});
    end
    @(posedge iClk);
    #1 iReady = 1'b1;
    waitDone(20);

    // A second start during the run is ignored.
    repeat (2) @(negedge iClk);
    enBefore = enCount;
    pulseStart();
    pushRun(8'h00, 8'h02, 8'hFD, 8'h04);
    repeat (4) @(posedge iClk);
    #1 iStart = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b0;
    waitDone(30);
    repeat (15) @(negedge iClk);
    checkVal("enCycles", enCount - enBefore, 32'd8);
    checkVal("busyIdle", {31'd0, oBusy}, 32'd0);

    // Asynchronous reset while element 2 is being presented.
    iReady = 1'b0;
    pulseStart();
    pushRun(8'h00, 8'h02, 8'hFD, 8'h04);
    waitValid(20);
    @(posedge iClk);
    #1 iReady = 1'b1;
    @(posedge iClk);
    #1;
    @(posedge iClk);
    #1 iReady = 1'b0;
    @(negedge iClk);
    checkVal("preRstIdx", {30'd0, oIdx}, 32'd2);
    #2 iRstN = 1'b0;
    sbQ.delete();
    #1 checkVal("rstMid", {28'd0, oValid, oEn, oClr, oBusy}, 32'd0);
    @(negedge iClk);
    #1 iRstN = 1'b1;
    iReady = 1'b1;
    repeat (16) begin
      @(negedge iClk);
      checkVal("quietAfterRst", {28'd0, oValid, oEn, oClr, oBusy}, 32'd0);
    end

`ifdef OUTERPRODRC_DRAIN_OVERLAP_EN
    // Start accepted mid-drain; the second drain must carry the fresh snapshot.
    iReady = 1'b0;
    pulseStart();
    pushRun(8'h00, 8'h02, 8'hFD, 8'h04);
    waitValid(20);
    @(posedge iClk);
    #1 iStart = 1'b1;
    pushRun(8'h44, 8'h33, 8'h22, 8'h11);
    @(posedge iClk);
    #1 iStart = 1'b0;
    @(negedge iClk);
    checkVal("ovClrWhileDrain", {30'd0, oClr, oValid}, 32'd3);
    iAccData = {8'h11, 8'h22, 8'h33, 8'h44};
    enBefore = enCount;
    repeat (14) @(negedge iClk);
    checkVal("ovHold", {20'd0, oValid, oEn, oIdx, oData}, {20'd0, 1'b1, 1'b0, 2'd0, 8'h00});
    checkVal("ovEnCycles", enCount - enBefore, 32'd8);
    @(posedge iClk);
    #1 iReady = 1'b1;
    waitDone(20);
    checkVal("ovBusyAtDone", {31'd0, oBusy}, 32'd1);
    waitDone(20);
    repeat (3) @(negedge iClk);
`endif

    checkVal("sbEmpty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule
